// File: rtl/fsmc_reg_bank_pkg.sv
// Shared definitions for the FSMC register bank: command FSM states, the
// SWAP/COPY opcode and the position of the GO/OP fields in the command word.
// Bit positions are counted down from the MSB because the data width is a
// parameter of the bank.
package fsmc_reg_bank_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StMove  = 2'd2,
    StStore = 2'd3
  } cmd_state_e;

  typedef enum logic {
    OpSwap = 1'b0,
    OpCopy = 1'b1
  } cmd_op_e;

  // Offsets below the command word MSB.
  localparam int unsigned GoPosFromMsb = 0;
  localparam int unsigned OpPosFromMsb = 1;

  // Number of status bits placed at the top of a CMD_ADDR read (BUSY, CMD_ERR).
  localparam int unsigned StatusBits = 2;

endpackage

// File: rtl/fsmc_reg_bank_wr_sync.sv
// FSMC strobe synchroniser and write capture.
// nCS/nOE/nWE are brought into CLK_IN through two flops each; nWE gets a third
// stage for rising-edge detection. While chip select and write strobe are both
// (synchronously) active, the raw address and data buses are sampled every
// cycle, so the last value seen before the strobe release is the one committed.
// Ports:
//   CLK_IN, RESET    clock, asynchronous active-low reset
//   fsmc_*_i         raw FSMC pins (address, strobes, write data)
//   commit_o         one-cycle pulse per write-strobe release
//   cap_add_o/dat_o  captured address/data, stable while commit_o is high
//   ncs_s2_o/noe_s2_o synchronised chip select / output enable
module fsmc_reg_bank_wr_sync #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK_IN,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] fsmc_add_i,
  input  logic              fsmc_ncs_i,
  input  logic              fsmc_nwe_i,
  input  logic              fsmc_noe_i,
  input  logic [DATA_W-1:0] fsmc_data_i,
  output logic              commit_o,
  output logic [ADDR_W-1:0] cap_add_o,
  output logic [DATA_W-1:0] cap_dat_o,
  output logic              ncs_s2_o,
  output logic              noe_s2_o
);

  logic ncs_s1_q, ncs_s2_q;
  logic noe_s1_q, noe_s2_q;
  logic nwe_s1_q, nwe_s2_q, nwe_s3_q;

  logic              commit_d, commit_q;
  logic [ADDR_W-1:0] cap_add_d, cap_add_q;
  logic [DATA_W-1:0] cap_dat_d, cap_dat_q;

  always_comb begin
    cap_add_d = cap_add_q;
    cap_dat_d = cap_dat_q;
    if (!ncs_s2_q && !nwe_s2_q) begin
      cap_add_d = fsmc_add_i;
      cap_dat_d = fsmc_data_i;
    end
    // Registered so the register array sees a clean pulse; this puts the
    // register update on the 4th CLK_IN edge after the nWE pin rises.
    commit_d = nwe_s2_q & ~nwe_s3_q;
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      ncs_s1_q  <= 1'b1;
      ncs_s2_q  <= 1'b1;
      noe_s1_q  <= 1'b1;
      noe_s2_q  <= 1'b1;
      nwe_s1_q  <= 1'b1;
      nwe_s2_q  <= 1'b1;
      nwe_s3_q  <= 1'b1;
      commit_q  <= 1'b0;
      cap_add_q <= '0;
      cap_dat_q <= '0;
    end else begin
      ncs_s1_q  <= fsmc_ncs_i;
      ncs_s2_q  <= ncs_s1_q;
      noe_s1_q  <= fsmc_noe_i;
      noe_s2_q  <= noe_s1_q;
      nwe_s1_q  <= fsmc_nwe_i;
      nwe_s2_q  <= nwe_s1_q;
      nwe_s3_q  <= nwe_s2_q;
      commit_q  <= commit_d;
      cap_add_q <= cap_add_d;
      cap_dat_q <= cap_dat_d;
    end
  end

  assign commit_o  = commit_q;
  assign cap_add_o = cap_add_q;
  assign cap_dat_o = cap_dat_q;
  assign ncs_s2_o  = ncs_s2_q;
  assign noe_s2_o  = noe_s2_q;

endmodule

// File: rtl/fsmc_reg_bank.sv
// FSMC-mapped register bank with an in-fabric SWAP/COPY command engine.
// N_REGS data registers live at addresses 0..N_REGS-1; a command register sits
// at N_REGS. Writing a command with GO set starts a SWAP (LOAD, MOVE, STORE)
// or COPY (MOVE) between two registers; BUSY is high while the FSM runs and
// CMD_ERR latches rejected commands or data writes attempted while busy.
// Ports:
//   CLK_IN, RESET     clock, asynchronous active-low reset
//   FSMC_*            MCU bus: address, active-low strobes, write data
//   FSMC_DATAOUT/DOE  registered read data and its tristate enable
//   REG_Q             all registers flattened, reg i at [i*DATA_W +: DATA_W]
//   BUSY, CMD_ERR     command FSM status
module fsmc_reg_bank
  import fsmc_reg_bank_pkg::*;
#(
  parameter int unsigned N_REGS = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic                     CLK_IN,
  input  logic                     RESET,
  input  logic [ADDR_W-1:0]        FSMC_ADD,
  input  logic                     FSMC_nCS,
  input  logic                     FSMC_NWE,
  input  logic                     FSMC_NOE,
  input  logic [DATA_W-1:0]        FSMC_DATAIN,
  output logic [DATA_W-1:0]        FSMC_DATAOUT,
  output logic                     FSMC_DOE,
  output logic [N_REGS*DATA_W-1:0] REG_Q,
  output logic                     BUSY,
  output logic                     CMD_ERR
);

  localparam int unsigned IDX_W = $clog2(N_REGS);
  localparam int unsigned GoBit = DATA_W - 1 - GoPosFromMsb;
  localparam int unsigned OpBit = DATA_W - 1 - OpPosFromMsb;
  localparam logic [ADDR_W-1:0] CmdAddr = ADDR_W'(N_REGS);

  logic              commit;
  logic [ADDR_W-1:0] cap_add;
  logic [DATA_W-1:0] cap_dat;
  logic              ncs_s2, noe_s2;

  fsmc_reg_bank_wr_sync #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr_sync (
    .CLK_IN      (CLK_IN),
    .RESET       (RESET),
    .fsmc_add_i  (FSMC_ADD),
    .fsmc_ncs_i  (FSMC_nCS),
    .fsmc_nwe_i  (FSMC_NWE),
    .fsmc_noe_i  (FSMC_NOE),
    .fsmc_data_i (FSMC_DATAIN),
    .commit_o    (commit),
    .cap_add_o   (cap_add),
    .cap_dat_o   (cap_dat),
    .ncs_s2_o    (ncs_s2),
    .noe_s2_o    (noe_s2)
  );

  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] tmp_d, tmp_q;
  cmd_state_e        state_d, state_q;
  cmd_op_e           op_d, op_q;
  logic [IDX_W-1:0]  src_d, src_q;
  logic [IDX_W-1:0]  dst_d, dst_q;
  logic              busy_d, busy_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] dout_d, dout_q;
  logic              doe_d, doe_q;

  // Command word fields as seen on the captured write data.
  logic             cmd_go;
  cmd_op_e          cmd_op;
  logic [IDX_W-1:0] cmd_src, cmd_dst;
  logic             cmd_bad_idx;
  logic             cap_is_data, cap_is_cmd;
  logic [IDX_W-1:0] cap_idx;

  assign cmd_go      = cap_dat[GoBit];
  assign cmd_op      = cmd_op_e'(cap_dat[OpBit]);
  assign cmd_src     = cap_dat[IDX_W-1:0];
  assign cmd_dst     = cap_dat[2*IDX_W-1:IDX_W];
  // Only reachable when N_REGS is not a power of two.
  assign cmd_bad_idx = (32'(cmd_src) >= N_REGS) || (32'(cmd_dst) >= N_REGS);
  assign cap_is_data = 32'(cap_add) < N_REGS;
  assign cap_is_cmd  = cap_add == CmdAddr;
  assign cap_idx     = cap_add[IDX_W-1:0];

  always_comb begin
    regs_d  = regs_q;
    tmp_d   = tmp_q;
    state_d = state_q;
    op_d    = op_q;
    src_d   = src_q;
    dst_d   = dst_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        tmp_d   = regs_q[dst_q];
        state_d = StMove;
      end
      StMove: begin
        regs_d[dst_q] = regs_q[src_q];
        state_d       = (op_q == OpSwap) ? StStore : StIdle;
      end
      StStore: begin
        regs_d[src_q] = tmp_q;
        state_d       = StIdle;
      end
    endcase

    // Bus writes never collide with FSM writes: data writes are dropped and
    // GO is rejected whenever the FSM is running.
    if (commit) begin
      if (cap_is_data) begin
        if (busy_q) begin
          err_d = 1'b1;
        end else begin
          regs_d[cap_idx] = cap_dat;
        end
      end else if (cap_is_cmd) begin
        if (!cmd_go) begin
          err_d = 1'b0;
        end else if (busy_q || cmd_bad_idx) begin
          err_d = 1'b1;
        end else begin
          op_d    = cmd_op;
          src_d   = cmd_src;
          dst_d   = cmd_dst;
          state_d = (cmd_op == OpSwap) ? StLoad : StMove;
        end
      end
    end

    busy_d = (state_d != StIdle);
  end

  // Read path: the raw address selects, the mux output is registered every
  // cycle so DATAOUT only ever shows a whole pre- or post-edge value.
  always_comb begin
    doe_d  = ~ncs_s2 & ~noe_s2;
    dout_d = '0;
    if (32'(FSMC_ADD) < N_REGS) begin
      dout_d = regs_q[FSMC_ADD[IDX_W-1:0]];
    end else if (FSMC_ADD == CmdAddr) begin
      dout_d[DATA_W-1] = busy_q;
      dout_d[DATA_W-2] = err_q;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET) begin
    if (!RESET) begin
      regs_q  <= '{default: '0};
      tmp_q   <= '0;
      state_q <= StIdle;
      op_q    <= OpSwap;
      src_q   <= '0;
      dst_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= '0;
      doe_q   <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      tmp_q   <= tmp_d;
      state_q <= state_d;
      op_q    <= op_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      doe_q   <= doe_d;
    end
  end

  always_comb begin
    REG_Q = '0;
    for (int i = 0; i < int'(N_REGS); i++) begin
      REG_Q[i*DATA_W +: DATA_W] = regs_q[i];
    end
  end

  assign FSMC_DATAOUT = dout_q;
  assign FSMC_DOE     = doe_q;
  assign BUSY         = busy_q;
  assign CMD_ERR      = err_q;

endmodule
